mem_demux: RTL

Parametrised single-master memory router that replaces the hand-written address-decode `always_comb` in the SoC top. It steers the CPU memory port to one of `NSLV` slave ports through a parameter-defined address map and subtracts the matched slave's base address. It holds one outstanding transaction in a small FSM, returns a registered response, and converts unmapped accesses and unresponsive slaves (timeout) into error responses with a captured fault address.

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_decode.sv | 33 +++
 rtl/mem_demux.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state type and default SoC address map for the memory router.
package bus_pkg;
  localparam int MAX_SLV = 16;
  localparam int IDX_W = $clog2(MAX_SLV);
  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] clint_top_addr  = 32'h0200_C000;
  localparam logic [31:0] clic_base_addr  = 32'h0C00_0000;
  localparam logic [31:0] clic_top_addr   = 32'h0C40_0000;
  localparam logic [31:0] print_base_addr = 32'h1000_0000;
  localparam logic [31:0] print_top_addr  = 32'h1000_1000;
  localparam logic [31:0] bram_base_addr  = 32'h8000_0000;
  localparam logic [31:0] bram_top_addr   = 32'h8010_0000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/bus_decode.sv
// bus_decode: combinational address map lookup returning hit, slave index and base-relative offset.
module bus_decode import bus_pkg::*; #(
  parameter int NSLV = 4,
  parameter logic [NSLV-1:0][31:0] BASE = {bram_base_addr, print_base_addr, clic_base_addr, clint_base_addr},
  parameter logic [NSLV-1:0][31:0] TOP = {bram_top_addr, print_top_addr, clic_top_addr, clint_top_addr},
  parameter bit ALIAS_EN = 1'b1,
  parameter logic [31:0] ALIAS_ADDR = 32'h8010_0000,
  parameter int ALIAS_IDX = 3
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic [31:0]      offset
);
  // Scan from the top down so the lowest matching index overwrites the rest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    offset = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (addr >= BASE[i] && addr < TOP[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
        offset = addr - BASE[i];
      end
    end
    if (!hit && ALIAS_EN && addr == ALIAS_ADDR) begin
      hit = 1'b1;
      idx = IDX_W'(ALIAS_IDX);
      offset = addr - BASE[ALIAS_IDX];
    end
  end
endmodule

// File: rtl/mem_demux.sv
// mem_demux: single-outstanding memory router with address decode, timeout and fault capture.
module mem_demux import bus_pkg::*; #(
  parameter int NSLV = 4,
  parameter logic [NSLV-1:0][31:0] BASE = {bram_base_addr, print_base_addr, clic_base_addr, clint_base_addr},
  parameter logic [NSLV-1:0][31:0] TOP = {bram_top_addr, print_top_addr, clic_top_addr, clint_top_addr},
  parameter bit ALIAS_EN = 1'b1,
  parameter logic [31:0] ALIAS_ADDR = 32'h8010_0000,
  parameter int ALIAS_IDX = 3,
  parameter int TMO_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memory_valid,
  input  logic                  memory_instr,
  input  logic [31:0]           memory_addr,
  input  logic [31:0]           memory_wdata,
  input  logic [3:0]            memory_wstrb,
  output logic [31:0]           memory_rdata,
  output logic                  memory_error,
  output logic                  memory_ready,
  output logic [NSLV-1:0]       slv_valid,
  output logic                  slv_instr,
  output logic [31:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  output logic [3:0]            slv_wstrb,
  input  logic [NSLV-1:0][31:0] slv_rdata,
  input  logic [NSLV-1:0]       slv_ready,
  output logic                  fault,
  output logic [31:0]           fault_addr
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, dec_idx, sel_idx;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] rdata_q, rdata_d, addr_q, addr_d, fault_addr_q, fault_addr_d, dec_offset, sel_rdata;
  logic err_q, err_d, dec_hit, accept, sel_rdy, resp;

  bus_decode #(
    .NSLV(NSLV), .BASE(BASE), .TOP(TOP),
    .ALIAS_EN(ALIAS_EN), .ALIAS_ADDR(ALIAS_ADDR), .ALIAS_IDX(ALIAS_IDX)
  ) u_dec (
    .addr(memory_addr), .hit(dec_hit), .idx(dec_idx), .offset(dec_offset)
  );

  assign accept = memory_valid && state_q != WAIT;
  assign sel_idx = accept ? dec_idx : idx_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign resp = state_q == RESP;

  always_comb begin
    sel_rdy = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      slv_valid[i] = reset && accept && dec_hit && dec_idx == IDX_W'(i);
      if (sel_idx == IDX_W'(i)) begin
        sel_rdy = slv_ready[i];
        sel_rdata = slv_rdata[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    addr_d = addr_q;
    fault_addr_d = fault_addr_q;
    if (accept) begin
      addr_d = memory_addr;
      idx_d = dec_idx;
      cnt_d = '0;
      if (!dec_hit) begin
        state_d = RESP;
        err_d = 1'b1;
        rdata_d = '0;
        fault_addr_d = memory_addr;
      end else if (sel_rdy) begin
        state_d = RESP;
        err_d = 1'b0;
        rdata_d = sel_rdata;
      end else begin
        state_d = WAIT;
      end
    end else if (state_q == WAIT) begin
      // Timeout lands so the error response is 2^TMO_W cycles after accept.
      if (sel_rdy) begin
        state_d = RESP;
        err_d = 1'b0;
        rdata_d = sel_rdata;
      end else if (&cnt_inc) begin
        state_d = RESP;
        err_d = 1'b1;
        rdata_d = '0;
        fault_addr_d = addr_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (resp) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      addr_q <= addr_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign memory_ready = resp;
  assign memory_rdata = resp ? rdata_q : '0;
  assign memory_error = resp && err_q;
  assign fault = resp && err_q;
  assign fault_addr = fault_addr_q;
  assign slv_instr = reset && memory_instr;
  assign slv_addr = reset ? dec_offset : '0;
  assign slv_wdata = reset ? memory_wdata : '0;
  assign slv_wstrb = reset ? memory_wstrb : '0;
endmodule
